// File: rtl/k423_if_bpu.sv
// IF-stage branch prediction unit: direct-mapped BTB with 2-bit counters plus a
// return address stack, trained only from resolved BJU updates.
module k423_if_bpu #(
    parameter int BTB_DEPTH   = 16,
    parameter int TAG_W       = 8,
    parameter int RAS_DEPTH   = 4,
    parameter int CORE_ADDR_W = 32,
    parameter int CORE_XLEN   = 32,
    parameter int BR_TYPE_W   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   if_vld_i,
    input  logic [CORE_ADDR_W-1:0] if_pc_i,
    output logic                   bpu_prd_tkn_o,
    output logic [CORE_ADDR_W-1:0] bpu_prd_pc_o,
    output logic [1:0]             bpu_prd_sat_cnt_o,
    input  logic                   bju_upd_vld_i,
    input  logic                   bju_upd_mis_i,
    input  logic                   bju_upd_tkn_i,
    input  logic [BR_TYPE_W-1:0]   bju_upd_type_i,
    input  logic [CORE_XLEN-1:0]   bju_upd_src_pc_i,
    input  logic [CORE_XLEN-1:0]   bju_upd_tgt_pc_i,
    input  logic [1:0]             bju_upd_sat_cnt_i,
    output logic [31:0]            bpu_mis_cnt_o
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int RP_W  = $clog2(RAS_DEPTH);
    localparam logic [RP_W:0] RAS_FULL = (RP_W+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        PHT_NTKN_STRONG = 2'b00,
        PHT_NTKN_WEAK   = 2'b01,
        PHT_TKN_WEAK    = 2'b10,
        PHT_TKN_STRONG  = 2'b11
    } pht_e;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [CORE_ADDR_W-1:0] tgt;
        logic [1:0]             typ;
        logic [1:0]             sat;
    } btb_ent_t;

    logic [BTB_DEPTH-1:0]   vld_q;
    btb_ent_t               btb_q [BTB_DEPTH];
    logic [CORE_ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [RP_W-1:0]        ras_ptr_q, ras_ptr_d;
    logic [RP_W:0]          ras_cnt_q, ras_cnt_d;
    logic [31:0]            mis_cnt_q, mis_cnt_d;

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0]       lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic [CORE_ADDR_W-1:0] ras_top;
    logic [CORE_ADDR_W-1:0] seq_pc;

    assign lk_idx  = if_pc_i[IDX_W+1:2];
    assign lk_tag  = if_pc_i[IDX_W+2 +: TAG_W];
    assign lk_hit  = if_vld_i && vld_q[lk_idx] && (btb_q[lk_idx].tag == lk_tag);
    assign ras_top = ras_q[ras_ptr_q - RP_W'(1)];
    assign seq_pc  = if_pc_i + CORE_ADDR_W'(4);

    // NOTE: every output gets a default before the if, so no latch is inferred.
    always_comb begin
        bpu_prd_tkn_o     = 1'b0;
        bpu_prd_pc_o      = seq_pc;
        bpu_prd_sat_cnt_o = PHT_NTKN_WEAK;
        if (lk_hit) begin
            bpu_prd_sat_cnt_o = btb_q[lk_idx].sat;
            bpu_prd_tkn_o     = btb_q[lk_idx].sat[1];
            if (btb_q[lk_idx].sat[1]) begin
                bpu_prd_pc_o = (btb_q[lk_idx].typ[1] && (ras_cnt_q != '0)) ? ras_top
                                                                           : btb_q[lk_idx].tgt;
            end
        end
    end

    // ---------------------------------------------------------------- update
    logic [IDX_W-1:0]       up_idx;
    logic [TAG_W-1:0]       up_tag;
    logic                   up_hit;
    logic                   up_wr;
    logic [1:0]             up_type;
    logic [CORE_ADDR_W-1:0] ras_push_val;
    logic                   ras_wr_en;
    logic [RP_W-1:0]        ras_wr_idx;

    assign up_idx       = bju_upd_src_pc_i[IDX_W+1:2];
    assign up_tag       = bju_upd_src_pc_i[IDX_W+2 +: TAG_W];
    assign up_hit       = vld_q[up_idx] && (btb_q[up_idx].tag == up_tag);
    assign up_wr        = bju_upd_vld_i && (up_hit || bju_upd_tkn_i);
    assign up_type      = bju_upd_type_i[1:0];
    assign ras_push_val = CORE_ADDR_W'(bju_upd_src_pc_i + CORE_XLEN'(4));

    // RAS pointer addresses the next free slot; the top lives at ptr-1.
    always_comb begin
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = ras_ptr_q;
        if (bju_upd_vld_i && bju_upd_tkn_i) begin
            unique case (up_type)
                2'b01: begin
                    ras_wr_en = 1'b1;
                    ras_ptr_d = ras_ptr_q + RP_W'(1);
                    ras_cnt_d = (ras_cnt_q == RAS_FULL) ? ras_cnt_q : ras_cnt_q + 1'b1;
                end
                2'b10: begin
                    if (ras_cnt_q != '0) begin
                        ras_ptr_d = ras_ptr_q - RP_W'(1);
                        ras_cnt_d = ras_cnt_q - 1'b1;
                    end
                end
                2'b11: begin
                    ras_wr_en = 1'b1;
                    if (ras_cnt_q == '0) begin
                        ras_ptr_d = ras_ptr_q + RP_W'(1);
                        ras_cnt_d = (RP_W+1)'(1);
                    end else begin
                        ras_wr_idx = ras_ptr_q - RP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mis_cnt_d = mis_cnt_q + 32'(bju_upd_vld_i & bju_upd_mis_i);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // see the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q     <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (up_wr) vld_q[up_idx] <= 1'b1;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // NOTE: table storage has no reset; the valid bits and RAS count gate every
    // read, so leaving the arrays unreset keeps them plain RAM-style memories.
    always_ff @(posedge clk_i) begin
        if (up_wr) begin
            btb_q[up_idx].tag <= up_tag;
            btb_q[up_idx].typ <= up_type;
            btb_q[up_idx].sat <= bju_upd_sat_cnt_i;
            if (bju_upd_tkn_i) btb_q[up_idx].tgt <= CORE_ADDR_W'(bju_upd_tgt_pc_i);
        end
        if (ras_wr_en) ras_q[ras_wr_idx] <= ras_push_val;
    end

    assign bpu_mis_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_k423_if_bpu.sv
// Self-checking bench for k423_if_bpu: a map/queue reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_k423_if_bpu;

    localparam int BTB_DEPTH = 16;
    localparam int TAG_W     = 8;
    localparam int IDX_W     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_vld;
    logic [31:0] if_pc;
    logic        prd_tkn;
    logic [31:0] prd_pc;
    logic [1:0]  prd_sat;
    logic        upd_vld, upd_mis, upd_tkn;
    logic [1:0]  upd_type;
    logic [31:0] upd_src, upd_tgt;
    logic [1:0]  upd_sat;
    logic [31:0] mis_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    k423_if_bpu dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .if_vld_i          (if_vld),
        .if_pc_i           (if_pc),
        .bpu_prd_tkn_o     (prd_tkn),
        .bpu_prd_pc_o      (prd_pc),
        .bpu_prd_sat_cnt_o (prd_sat),
        .bju_upd_vld_i     (upd_vld),
        .bju_upd_mis_i     (upd_mis),
        .bju_upd_tkn_i     (upd_tkn),
        .bju_upd_type_i    (upd_type),
        .bju_upd_src_pc_i  (upd_src),
        .bju_upd_tgt_pc_i  (upd_tgt),
        .bju_upd_sat_cnt_i (upd_sat),
        .bpu_mis_cnt_o     (mis_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    typedef struct {
        bit [7:0]  tag;
        bit [31:0] tgt;
        bit [1:0]  typ;
        bit [1:0]  sat;
    } ent_t;

    ent_t        m_btb [int];
    int unsigned m_ras [$];
    int unsigned m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % BTB_DEPTH);
    endfunction

    function automatic bit [7:0] tag_of(input logic [31:0] pc);
        return 8'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic void predict(input logic vld, input logic [31:0] pc,
                                    output logic tkn, output logic [31:0] npc,
                                    output logic [1:0] sat);
        int i;
        tkn = 1'b0;
        npc = pc + 32'd4;
        sat = 2'b01;
        i   = idx_of(pc);
        if (vld && m_btb.exists(i) && m_btb[i].tag == tag_of(pc)) begin
            sat = m_btb[i].sat;
            tkn = (m_btb[i].sat >= 2);
            if (tkn) npc = (m_btb[i].typ[1] && m_ras.size() > 0) ? m_ras[$] : m_btb[i].tgt;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_btb.delete();
            m_ras.delete();
            m_mis = 0;
        end else if (upd_vld) begin
            int  i;
            bit  hit;
            i   = idx_of(upd_src);
            hit = m_btb.exists(i) && m_btb[i].tag == tag_of(upd_src);
            if (hit || upd_tkn) begin
                ent_t e;
                e.tgt = hit ? m_btb[i].tgt : 32'h0;
                if (upd_tkn) e.tgt = upd_tgt;
                e.tag = tag_of(upd_src);
                e.typ = upd_type;
                e.sat = upd_sat;
                m_btb[i] = e;
            end
            if (upd_tkn) begin
                case (upd_type)
                    2'b01: begin
                        m_ras.push_back(upd_src + 4);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                    end
                    2'b10: if (m_ras.size() > 0) void'(m_ras.pop_back());
                    2'b11: begin
                        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = upd_src + 4;
                        else m_ras.push_back(upd_src + 4);
                    end
                    default: ;
                endcase
            end
            if (upd_mis) m_mis++;
        end
    end

    always @(negedge clk) begin
        logic        e_tkn;
        logic [31:0] e_pc;
        logic [1:0]  e_sat;
        predict(if_vld, if_pc, e_tkn, e_pc, e_sat);
        check("cyc_tkn", 32'(prd_tkn), 32'(e_tkn));
        check("cyc_pc", prd_pc, e_pc);
        check("cyc_sat", 32'(prd_sat), 32'(e_sat));
        check("cyc_mis_cnt", mis_cnt, m_mis);
    end

    // ---------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] src, input logic tkn, input logic [31:0] tgt,
                       input logic [1:0] typ, input logic [1:0] sat, input logic mis);
        upd_vld  = 1'b1;
        upd_src  = src;
        upd_tkn  = tkn;
        upd_tgt  = tgt;
        upd_type = typ;
        upd_sat  = sat;
        upd_mis  = mis;
        tick();
        upd_vld  = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic e_tkn,
                        input logic [31:0] e_pc, input logic [1:0] e_sat);
        if_vld = 1'b1;
        if_pc  = pc;
        #1;
        check({name, "_tkn"}, 32'(prd_tkn), 32'(e_tkn));
        check({name, "_pc"}, prd_pc, e_pc);
        check({name, "_sat"}, 32'(prd_sat), 32'(e_sat));
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        if_vld   = 1'b0;
        if_pc    = 32'h0;
        upd_vld  = 1'b0;
        upd_mis  = 1'b0;
        upd_tkn  = 1'b0;
        upd_type = 2'b00;
        upd_src  = 32'h0;
        upd_tgt  = 32'h0;
        upd_sat  = 2'b00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        check("reset_mis_cnt", mis_cnt, 32'd0);
        look("cold", 32'h100, 1'b0, 32'h104, 2'b01);

        // allocate, then train down and back up without a new target
        upd(32'h100, 1'b1, 32'h200, 2'b00, 2'b10, 1'b0);
        look("alloc", 32'h100, 1'b1, 32'h200, 2'b10);
        upd(32'h100, 1'b0, 32'hdead, 2'b00, 2'b01, 1'b0);
        look("train_nt", 32'h100, 1'b0, 32'h104, 2'b01);
        upd(32'h100, 1'b0, 32'hbeef, 2'b00, 2'b10, 1'b0);
        look("keep_tgt", 32'h100, 1'b1, 32'h200, 2'b10);

        // not-taken miss never allocates
        upd(32'h300, 1'b0, 32'h999, 2'b00, 2'b11, 1'b0);
        look("no_alloc", 32'h300, 1'b0, 32'h304, 2'b01);
        look("no_alloc_keep", 32'h100, 1'b1, 32'h200, 2'b10);

        // aliasing: same index, different tag
        upd(32'h140, 1'b1, 32'h500, 2'b00, 2'b11, 1'b0);
        look("alias_old", 32'h100, 1'b0, 32'h104, 2'b01);
        look("alias_new", 32'h140, 1'b1, 32'h500, 2'b11);

        // lookup with if_vld low reads as a miss
        if_vld = 1'b0;
        if_pc  = 32'h140;
        #1;
        check("if_vld_low_tkn", 32'(prd_tkn), 32'd0);
        check("if_vld_low_pc", prd_pc, 32'h144);
        tick();

        // RAS: ret entry first (pop on empty is a no-op), then five calls
        upd(32'h404, 1'b1, 32'h600, 2'b10, 2'b11, 1'b0);
        look("ret_empty", 32'h404, 1'b1, 32'h600, 2'b11);
        for (int i = 1; i <= 5; i++) upd(32'(i * 16), 1'b1, 32'h1000, 2'b01, 2'b11, 1'b0);
        look("ras_top", 32'h404, 1'b1, 32'h54, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_pop1", 32'h404, 1'b1, 32'h44, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_pop2", 32'h404, 1'b1, 32'h34, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_pop3", 32'h404, 1'b1, 32'h24, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_empty", 32'h404, 1'b1, 32'h700, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_underflow", 32'h404, 1'b1, 32'h700, 2'b11);

        // pop+push on empty and non-empty stacks
        upd(32'h80, 1'b1, 32'h2000, 2'b11, 2'b11, 1'b0);
        look("ras_xchg_empty", 32'h404, 1'b1, 32'h84, 2'b11);
        upd(32'h90, 1'b1, 32'h2000, 2'b11, 2'b11, 1'b0);
        look("ras_xchg", 32'h404, 1'b1, 32'h94, 2'b11);
        upd(32'h80, 1'b1, 32'h3000, 2'b00, 2'b11, 1'b0);
        look("ras_type00", 32'h404, 1'b1, 32'h94, 2'b11);
        upd(32'h404, 1'b1, 32'h700, 2'b10, 2'b11, 1'b0);
        look("ras_xchg_pop", 32'h404, 1'b1, 32'h700, 2'b11);

        // same-cycle lookup and update of one index sees old contents
        if_vld = 1'b1;
        if_pc  = 32'h404;
        upd_vld  = 1'b1;
        upd_src  = 32'h404;
        upd_tkn  = 1'b1;
        upd_tgt  = 32'h900;
        upd_type = 2'b00;
        upd_sat  = 2'b10;
        upd_mis  = 1'b0;
        #1;
        check("bypass_old_pc", prd_pc, 32'h700);
        check("bypass_old_sat", 32'(prd_sat), 32'd3);
        tick();
        upd_vld = 1'b0;
        look("bypass_new", 32'h404, 1'b1, 32'h900, 2'b10);

        // misprediction counter
        upd(32'h800, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        upd(32'h404, 1'b1, 32'h900, 2'b00, 2'b11, 1'b1);
        upd(32'h800, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        check("mis_cnt_3", mis_cnt, 32'd3);

        // asynchronous reset mid-cycle, with an update in flight
        if_vld  = 1'b1;
        if_pc   = 32'h404;
        upd_vld = 1'b1;
        upd_src = 32'h404;
        upd_tkn = 1'b1;
        upd_mis = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("rst_mis_cnt", mis_cnt, 32'd0);
        check("rst_tkn", 32'(prd_tkn), 32'd0);
        check("rst_pc", prd_pc, 32'h408);
        check("rst_sat", 32'(prd_sat), 32'd1);
        tick();
        upd_vld = 1'b0;
        rst_n   = 1'b1;
        tick();
        look("post_rst_404", 32'h404, 1'b0, 32'h408, 2'b01);
        look("post_rst_140", 32'h140, 1'b0, 32'h144, 2'b01);
        check("post_rst_mis_cnt", mis_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
